// File: rtl/flag_branch_ctrl.sv
// flag_branch_ctrl: NZVC flag register plus a conditional-branch resolver.
// Ports: clk, reset (async active-low); ALU result/flags and set_flags in;
//   br_valid/br_type/br_ready request handshake; res_valid/res_taken/
//   res_ready decision handshake; flags {N,Z,V,C}; taken_cnt saturating.
module flag_branch_ctrl #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_neg,
    input  logic             alu_ovf,
    input  logic             alu_carry,
    input  logic             set_flags,
    input  logic             br_valid,
    input  logic [2:0]       br_type,
    output logic             br_ready,
    output logic             res_valid,
    output logic             res_taken,
    input  logic             res_ready,
    output logic [3:0]       flags,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        RESOLVE,
        HOLD
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             live_q;
    logic [3:0]       flags_q;
    logic [3:0]       flags_d;
    logic             taken_q;
    logic             taken_d;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;
    logic             consume;
    logic             decide;

    // The CBZ/CBNZ zero test arrives pre-computed on alu_zero.
    logic unused_result;
    assign unused_result = ^alu_result;

    // Flags as they will be after this edge; B.cond sees forwarded values.
    assign flags_d = set_flags
                   ? {alu_neg, alu_zero, alu_ovf, alu_carry}
                   : flags_q;

    always_comb begin
        decide = 1'b0;
        case (br_type)
            3'd0:    decide = 1'b1;
            3'd1:    decide = alu_zero;
            3'd2:    decide = ~alu_zero;
            3'd3:    decide = flags_d[2];
            3'd4:    decide = ~flags_d[2];
            3'd5:    decide = flags_d[3] ^ flags_d[1];
            3'd6:    decide = ~(flags_d[3] ^ flags_d[1]);
            default: decide = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        br_ready  = 1'b0;
        res_valid = 1'b0;
        accept    = 1'b0;
        consume   = 1'b0;
        case (state_q)
            IDLE: begin
                // live_q keeps br_ready low until the first edge after reset.
                br_ready = live_q;
                accept   = br_valid & live_q;
                if (accept) begin
                    state_d = RESOLVE;
                end
            end
            RESOLVE: begin
                res_valid = 1'b1;
                consume   = res_ready;
                state_d   = res_ready ? IDLE : HOLD;
            end
            HOLD: begin
                res_valid = 1'b1;
                consume   = res_ready;
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The decision is frozen at acceptance so HOLD ignores later ALU activity.
    assign taken_d = accept ? decide : taken_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            live_q  <= 1'b0;
            flags_q <= 4'b0000;
            taken_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
            flags_q <= flags_d;
            taken_q <= taken_d;
            if (consume && taken_q && !(&cnt_q)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign res_taken = taken_q & res_valid;
    assign flags     = flags_q;
    assign taken_cnt = cnt_q;

endmodule

// File: doc/flag_branch_ctrl.md
FLAG_BRANCH_CTRL -- requirements
Module: flag_branch_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 64, operand/result width of the ALU datapath.
REQ-002 SHALL have parameter: CNT_W, 16, width of the taken-branch statistics counter.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: alu_result  input  WIDTH  current ALU result, used for CBZ/CBNZ.
REQ-006 SHALL have port: alu_zero  input  1  zero flag from the ALU zero checker, 1 when alu_result is all zeros.
REQ-007 SHALL have port: alu_neg, alu_ovf, alu_carry  input  1 each  ALU negative/overflow/carry flags.
REQ-008 SHALL have port: set_flags  input  1  latch {N,Z,V,C} from the ALU this cycle.
REQ-009 SHALL have port: br_valid  input  1  branch request present.
REQ-010 SHALL have port: br_type  input  3  0=B, 1=CBZ, 2=CBNZ, 3=B.EQ, 4=B.NE, 5=B.LT, 6=B.GE, 7=reserved.
REQ-011 SHALL have port: br_ready  output  1  request accepted when br_valid and br_ready are both 1.
REQ-012 SHALL have port: res_valid  output  1  decision available.
REQ-013 SHALL have port: res_taken  output  1  branch taken decision, meaningful only while res_valid=1.
REQ-014 SHALL have port: res_ready  input  1  consumer accepts decision when res_valid and res_ready are both 1.
REQ-015 SHALL have port: flags  output  4  architectural flag register {N,Z,V,C}.
REQ-016 SHALL have port: taken_cnt  output  CNT_W  saturating count of taken decisions delivered.

Function
REQ-017 SHALL update flags on each clock edge where set_flags=1 with {alu_neg, alu_zero, alu_ovf, alu_carry}, and otherwise hold them.
REQ-018 SHALL implement FSM states IDLE, RESOLVE and HOLD.
REQ-019 SHALL drive br_ready=1 only in IDLE.
REQ-020 SHALL, on acceptance in IDLE, capture br_type and the operand zero bit (alu_zero) and go to RESOLVE.
REQ-021 SHALL, in RESOLVE, compute res_taken and assert res_valid, giving one cycle of latency from acceptance to res_valid.
REQ-022 SHALL evaluate B.cond types against flags as updated in the acceptance cycle: if set_flags=1 in the acceptance cycle, the decision uses the new flags (forwarded).
REQ-023 SHALL use these decision rules:
  - B: taken=1.
  - CBZ: taken=captured zero bit; CBNZ: its inverse.
  - B.EQ: Z; B.NE: !Z; B.LT: N!=V; B.GE: N==V.
  - Reserved type 7: taken=0.
REQ-024 SHALL go from RESOLVE back to IDLE if res_ready=1, and otherwise to HOLD.
REQ-025 SHALL, in HOLD, keep res_valid and res_taken stable regardless of set_flags or alu_* changes, and return to IDLE on res_ready=1.
REQ-026 SHALL not accept a new request in the same cycle a decision is consumed; back-to-back throughput is one branch per 2 cycles.
REQ-027 SHALL increment taken_cnt by 1 on each handshake (res_valid & res_ready) with res_taken=1, saturating at 2^CNT_W-1 with no wrap.
REQ-028 SHALL keep br_type values with br_valid=0 from affecting any state.

Reset
REQ-029 SHALL, while reset=0 (asynchronous), force state=IDLE, flags=4'b0000, res_valid=0, res_taken=0, taken_cnt=0, and br_ready=0.
REQ-030 SHALL, after reset deasserts, drive br_ready=1 from the first clock edge.
REQ-031 SHALL, when reset asserts mid-request (RESOLVE or HOLD), discard the pending decision without counting it.

Verification
REQ-032 SHALL be covered by a bench scenario: set_flags=1 with alu_zero=1, then B.EQ accepted in the next cycle -> res_valid=1 one cycle later, res_taken=1, taken_cnt=1.
REQ-033 SHALL be covered by a bench scenario: B.LT accepted in the same cycle as set_flags with N=1,V=0 (old flags 0000) -> res_taken=1, using the forwarded flags.
REQ-034 SHALL be covered by a bench scenario: CBNZ with alu_result=64'h1 (alu_zero=0) and res_ready held 0 for 3 cycles while alu_zero toggles -> res_valid and res_taken=1 held stable through HOLD, br_ready=0 until consumed.
REQ-035 SHALL be covered by a bench scenario: taken_cnt preloaded by issuing 2^CNT_W-1 taken B branches, then one more B -> taken_cnt stays 16'hFFFF.
REQ-036 SHALL be covered by a bench scenario: reset pulsed low while in HOLD -> res_valid=0, flags=0000 and taken_cnt=0 immediately (asynchronously), br_ready=1 after release.
REQ-037 SHALL be covered by a bench scenario: br_type=7 accepted -> res_taken=0 and taken_cnt unchanged.
